// File: rtl/csr_unit_if.sv
// CSR access port. The core drives the request fields; the unit answers with
// the pre-write value and an illegal-access flag in the same cycle.
interface csr_unit_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
);
  logic              csr_en;
  logic [1:0]        csr_op;
  logic              rs1_zero;
  logic [ADDR_W-1:0] address;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata;
  logic              illegal;

  modport master (output csr_en, csr_op, rs1_zero, address, wdata,
                  input  rdata, illegal);
  modport slave  (input  csr_en, csr_op, rs1_zero, address, wdata,
                  output rdata, illegal);
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file: mstatus/mtvec/mscratch/mepc/mcause, 64-bit cycle and
// instret counters, trap entry and mret sequencing.
module csr_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  csr_unit_if.slave        bus,
  input  logic             retire,
  input  logic             trap,
  input  logic [WIDTH-1:0] trap_pc,
  input  logic [WIDTH-1:0] trap_cause,
  input  logic             mret,
  output logic [WIDTH-1:0] mtvec_out,
  output logic [WIDTH-1:0] mepc_out,
  output logic             mie_out
);

  localparam logic [ADDR_W-1:0] A_MSTATUS   = ADDR_W'(12'h300);
  localparam logic [ADDR_W-1:0] A_MTVEC     = ADDR_W'(12'h305);
  localparam logic [ADDR_W-1:0] A_MSCRATCH  = ADDR_W'(12'h340);
  localparam logic [ADDR_W-1:0] A_MEPC      = ADDR_W'(12'h341);
  localparam logic [ADDR_W-1:0] A_MCAUSE    = ADDR_W'(12'h342);
  localparam logic [ADDR_W-1:0] A_MCYCLE    = ADDR_W'(12'hB00);
  localparam logic [ADDR_W-1:0] A_MINSTRET  = ADDR_W'(12'hB02);
  localparam logic [ADDR_W-1:0] A_MCYCLEH   = ADDR_W'(12'hB80);
  localparam logic [ADDR_W-1:0] A_MINSTRETH = ADDR_W'(12'hB82);
  localparam logic [ADDR_W-1:0] A_CYCLE     = ADDR_W'(12'hC00);
  localparam logic [ADDR_W-1:0] A_INSTRET   = ADDR_W'(12'hC02);
  localparam logic [ADDR_W-1:0] A_CYCLEH    = ADDR_W'(12'hC80);
  localparam logic [ADDR_W-1:0] A_INSTRETH  = ADDR_W'(12'hC82);

  localparam bit               HAS_HI  = (WIDTH == 32);
  localparam logic [WIDTH-1:0] ALIGN4  = ~WIDTH'(3);
  localparam logic [63:0]      LO_MASK = 64'({WIDTH{1'b1}});

  logic             mie, mpie;
  logic [WIDTH-1:0] mtvec, mscratch, mepc, mcause;
  logic [63:0]      mcycle, minstret;
  logic [63:0]      mcycle_next, minstret_next;

  logic [WIDTH-1:0] old_val, new_val;
  logic             hit, eff_write, do_write;
  logic             sel_mstatus, sel_mtvec, sel_mscratch, sel_mepc, sel_mcause;
  logic             sel_cyc_lo, sel_cyc_hi, sel_ret_lo, sel_ret_hi;

  // Address decode and pre-write read value.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    old_val      = '0;
    hit          = 1'b1;
    sel_mstatus  = 1'b0;
    sel_mtvec    = 1'b0;
    sel_mscratch = 1'b0;
    sel_mepc     = 1'b0;
    sel_mcause   = 1'b0;
    sel_cyc_lo   = 1'b0;
    sel_cyc_hi   = 1'b0;
    sel_ret_lo   = 1'b0;
    sel_ret_hi   = 1'b0;
    case (bus.address)
      A_MSTATUS: begin
        sel_mstatus = 1'b1;
        old_val[3]  = mie;
        old_val[7]  = mpie;
      end
      A_MTVEC:    begin sel_mtvec    = 1'b1; old_val = mtvec;    end
      A_MSCRATCH: begin sel_mscratch = 1'b1; old_val = mscratch; end
      A_MEPC:     begin sel_mepc     = 1'b1; old_val = mepc;     end
      A_MCAUSE:   begin sel_mcause   = 1'b1; old_val = mcause;   end
      A_MCYCLE:   begin sel_cyc_lo   = 1'b1; old_val = WIDTH'(mcycle);   end
      A_MINSTRET: begin sel_ret_lo   = 1'b1; old_val = WIDTH'(minstret); end
      A_CYCLE:    old_val = WIDTH'(mcycle);
      A_INSTRET:  old_val = WIDTH'(minstret);
      // Upper-half aliases exist only in the 32-bit configuration.
      A_MCYCLEH: begin
        hit        = HAS_HI;
        sel_cyc_hi = HAS_HI;
        old_val    = HAS_HI ? WIDTH'(mcycle[63:32]) : '0;
      end
      A_MINSTRETH: begin
        hit        = HAS_HI;
        sel_ret_hi = HAS_HI;
        old_val    = HAS_HI ? WIDTH'(minstret[63:32]) : '0;
      end
      A_CYCLEH: begin
        hit     = HAS_HI;
        old_val = HAS_HI ? WIDTH'(mcycle[63:32]) : '0;
      end
      A_INSTRETH: begin
        hit     = HAS_HI;
        old_val = HAS_HI ? WIDTH'(minstret[63:32]) : '0;
      end
      default: hit = 1'b0;
    endcase

    case (bus.csr_op)
      2'b01:   new_val = bus.wdata;
      2'b10:   new_val = old_val | bus.wdata;
      2'b11:   new_val = old_val & ~bus.wdata;
      default: new_val = old_val;
    endcase
  end

  // Set/clear with a zero operand is a pure read and may touch read-only CSRs.
  assign eff_write   = bus.csr_en && (bus.csr_op != 2'b00) &&
                       !(bus.csr_op[1] && bus.rs1_zero);
  assign bus.illegal = bus.csr_en &&
                       (!hit || ((bus.address[11:10] == 2'b11) && eff_write));
  assign bus.rdata   = old_val;
  assign do_write    = eff_write && !bus.illegal && !trap;

  // A write to either half of a counter replaces that half and skips the tick.
  always_comb begin
    mcycle_next = mcycle + 64'd1;
    if (do_write && sel_cyc_lo)
      mcycle_next = (mcycle & ~LO_MASK) | (64'(new_val) & LO_MASK);
    else if (do_write && sel_cyc_hi)
      mcycle_next = (mcycle & LO_MASK) | {new_val[31:0], 32'h0};

    minstret_next = retire ? minstret + 64'd1 : minstret;
    if (do_write && sel_ret_lo)
      minstret_next = (minstret & ~LO_MASK) | (64'(new_val) & LO_MASK);
    else if (do_write && sel_ret_hi)
      minstret_next = (minstret & LO_MASK) | {new_val[31:0], 32'h0};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= mcycle_next;
      minstret <= minstret_next;
      if (do_write) begin
        if (sel_mtvec)    mtvec    <= new_val & ALIGN4;
        if (sel_mscratch) mscratch <= new_val;
        if (sel_mepc)     mepc     <= new_val & ALIGN4;
        if (sel_mcause)   mcause   <= new_val;
        if (sel_mstatus) begin
          mie  <= new_val[3];
          mpie <= new_val[7];
        end
      end
      // NOTE: non-blocking updates; the last assignment in this block wins, which
      // gives trap and mret priority over a same-cycle mstatus write.
      if (trap) begin
        mepc   <= trap_pc & ALIGN4;
        mcause <= trap_cause;
        mpie   <= mie;
        mie    <= 1'b0;
      end else if (mret) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end
    end
  end

  assign mtvec_out = mtvec;
  assign mepc_out  = mepc;
  assign mie_out   = mie;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit (WIDTH=32): a per-cycle vector table for the
// register/trap behaviour, then hand sequences for counters and async reset.
module tb_csr_unit;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 12;

  logic             clock = 1'b0;
  logic             reset;
  logic             retire, trap, mret;
  logic [WIDTH-1:0] trap_pc, trap_cause;
  logic [WIDTH-1:0] mtvec_out, mepc_out;
  logic             mie_out;

  csr_unit_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  csr_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .retire     (retire),
    .trap       (trap),
    .trap_pc    (trap_pc),
    .trap_cause (trap_cause),
    .mret       (mret),
    .mtvec_out  (mtvec_out),
    .mepc_out   (mepc_out),
    .mie_out    (mie_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic [1:0]  op;
    logic        rz;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        trap;
    logic [31:0] tpc;
    logic [31:0] tcause;
    logic        mret;
    logic        chk_rd;
    logic [31:0] rd;
    logic        ill;
    logic        mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic en, input logic [1:0] op, input logic rz,
                              input logic [11:0] addr, input logic [31:0] wdata,
                              input logic tr, input logic [31:0] tpc, input logic [31:0] tcause,
                              input logic mr, input logic chk_rd, input logic [31:0] rd,
                              input logic ill, input logic mie, input logic [31:0] mtvec,
                              input logic [31:0] mepc);
    vec_t v;
    v.en = en; v.op = op; v.rz = rz; v.addr = addr; v.wdata = wdata;
    v.trap = tr; v.tpc = tpc; v.tcause = tcause; v.mret = mr;
    v.chk_rd = chk_rd; v.rd = rd; v.ill = ill; v.mie = mie; v.mtvec = mtvec; v.mepc = mepc;
    return v;
  endfunction

  task automatic drive(input logic en, input logic [1:0] op, input logic rz,
                       input logic [11:0] addr, input logic [31:0] wd);
    bus.csr_en   = en;
    bus.csr_op   = op;
    bus.rs1_zero = rz;
    bus.address  = addr;
    bus.wdata    = wd;
  endtask

  task automatic read_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    drive(1'b1, 2'b00, 1'b0, addr, 32'h0);
    #1;
    check(name, bus.rdata, exp);
  endtask

  initial begin
    //          en op   rz addr    wdata         tr tpc     tcause mr chk rd            ill mie mtvec     mepc
    vecs.push_back(mk(1, 2'd0, 0, 12'h300, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h0,        0, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd1, 0, 12'h340, 32'hDEADBEEF, 0, 32'h0,   32'h0, 0, 1, 32'h0,        0, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd2, 1, 12'h340, 32'h10,       0, 32'h0,   32'h0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd0, 0, 12'h340, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd2, 0, 12'h340, 32'h10,       0, 32'h0,   32'h0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd3, 0, 12'h340, 32'hDEAD0000, 0, 32'h0,   32'h0, 0, 1, 32'hDEADBEFF, 0, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd0, 0, 12'h340, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h0000BEFF, 0, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd1, 0, 12'hC00, 32'h1,        0, 32'h0,   32'h0, 0, 0, 32'h0,        1, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd0, 0, 12'h7FF, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h0,        1, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd0, 0, 12'hC00, 32'h0,        0, 32'h0,   32'h0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd2, 1, 12'hC00, 32'h1,        0, 32'h0,   32'h0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd1, 0, 12'hC80, 32'h5,        0, 32'h0,   32'h0, 0, 1, 32'h0,        1, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd0, 0, 12'hB80, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h0,        0, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd1, 0, 12'h305, 32'h1003,     0, 32'h0,   32'h0, 0, 1, 32'h0,        0, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 2'd0, 0, 12'h305, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h1000,     0, 0, 32'h1000, 32'h0));
    vecs.push_back(mk(1, 2'd1, 0, 12'h300, 32'hFFFFFFFF, 0, 32'h0,   32'h0, 0, 1, 32'h0,        0, 0, 32'h1000, 32'h0));
    vecs.push_back(mk(1, 2'd0, 0, 12'h300, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h88,       0, 1, 32'h1000, 32'h0));
    vecs.push_back(mk(1, 2'd1, 0, 12'h340, 32'h55,       1, 32'h103, 32'hB, 0, 1, 32'h0000BEFF, 0, 1, 32'h1000, 32'h0));
    vecs.push_back(mk(1, 2'd0, 0, 12'h340, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h0000BEFF, 0, 0, 32'h1000, 32'h100));
    vecs.push_back(mk(1, 2'd0, 0, 12'h300, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h80,       0, 0, 32'h1000, 32'h100));
    vecs.push_back(mk(1, 2'd0, 0, 12'h342, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'hB,        0, 0, 32'h1000, 32'h100));
    vecs.push_back(mk(1, 2'd0, 0, 12'h341, 32'h0,        0, 32'h0,   32'h0, 1, 1, 32'h100,      0, 0, 32'h1000, 32'h100));
    vecs.push_back(mk(1, 2'd0, 0, 12'h300, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h88,       0, 1, 32'h1000, 32'h100));
    vecs.push_back(mk(1, 2'd3, 0, 12'h300, 32'h8,        0, 32'h0,   32'h0, 1, 1, 32'h88,       0, 1, 32'h1000, 32'h100));
    vecs.push_back(mk(1, 2'd0, 0, 12'h300, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h88,       0, 1, 32'h1000, 32'h100));
    vecs.push_back(mk(1, 2'd1, 0, 12'hC02, 32'h7,        1, 32'h207, 32'h2, 1, 1, 32'h0,        1, 1, 32'h1000, 32'h100));
    vecs.push_back(mk(1, 2'd0, 0, 12'h300, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h80,       0, 0, 32'h1000, 32'h204));
    vecs.push_back(mk(1, 2'd0, 0, 12'h342, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h2,        0, 0, 32'h1000, 32'h204));
    vecs.push_back(mk(1, 2'd1, 0, 12'h341, 32'hFFFFFFFF, 0, 32'h0,   32'h0, 0, 1, 32'h204,      0, 0, 32'h1000, 32'h204));
    vecs.push_back(mk(1, 2'd0, 0, 12'h341, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h1000, 32'hFFFFFFFC));
    vecs.push_back(mk(0, 2'd1, 0, 12'h340, 32'h1234,     0, 32'h0,   32'h0, 0, 0, 32'h0,        0, 0, 32'h1000, 32'hFFFFFFFC));
    vecs.push_back(mk(0, 2'd1, 0, 12'h7FF, 32'h1,        0, 32'h0,   32'h0, 0, 0, 32'h0,        0, 0, 32'h1000, 32'hFFFFFFFC));
    vecs.push_back(mk(1, 2'd0, 0, 12'h340, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h0000BEFF, 0, 0, 32'h1000, 32'hFFFFFFFC));
    vecs.push_back(mk(1, 2'd0, 0, 12'hB82, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h0,        0, 0, 32'h1000, 32'hFFFFFFFC));
    vecs.push_back(mk(1, 2'd1, 0, 12'h7FF, 32'h1,        0, 32'h0,   32'h0, 0, 1, 32'h0,        1, 0, 32'h1000, 32'hFFFFFFFC));
    vecs.push_back(mk(1, 2'd2, 1, 12'h300, 32'h0,        0, 32'h0,   32'h0, 0, 1, 32'h80,       0, 0, 32'h1000, 32'hFFFFFFFC));

    // Reset state.
    reset = 1'b1; retire = 1'b0; trap = 1'b0; mret = 1'b0;
    trap_pc = '0; trap_cause = '0;
    drive(1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    #2;
    check("reset mtvec_out", mtvec_out, 32'h0);
    check("reset mepc_out", mepc_out, 32'h0);
    check("reset mie_out", mie_out, 1'b0);
    read_chk("reset mcycle", 12'hB00, 32'h0);
    read_chk("reset mstatus", 12'h300, 32'h0);
    drive(1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    read_chk("mcycle first edge", 12'hB00, 32'h1);
    @(posedge clock); #1;

    // Vector table, one row per cycle; outputs sampled on the falling edge.
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].op, vecs[i].rz, vecs[i].addr, vecs[i].wdata);
      trap = vecs[i].trap; trap_pc = vecs[i].tpc; trap_cause = vecs[i].tcause;
      mret = vecs[i].mret;
      @(negedge clock);
      if (vecs[i].chk_rd) check($sformatf("v%0d rdata", i), bus.rdata, vecs[i].rd);
      check($sformatf("v%0d illegal", i), bus.illegal, vecs[i].ill);
      check($sformatf("v%0d mie_out", i), mie_out, vecs[i].mie);
      check($sformatf("v%0d mtvec_out", i), mtvec_out, vecs[i].mtvec);
      check($sformatf("v%0d mepc_out", i), mepc_out, vecs[i].mepc);
      @(posedge clock); #1;
    end
    trap = 1'b0; mret = 1'b0; trap_pc = '0; trap_cause = '0;

    // minstret: retire counting, write suppressing the tick, upper-half write.
    drive(1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    retire = 1'b1;
    repeat (3) @(posedge clock);
    #1 retire = 1'b0;
    @(negedge clock);
    read_chk("minstret count", 12'hB02, 32'h3);
    read_chk("instret alias", 12'hC02, 32'h3);
    @(posedge clock); #1;
    drive(1'b1, 2'b01, 1'b0, 12'hB02, 32'h10);
    retire = 1'b1;
    @(posedge clock); #1;
    drive(1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    @(posedge clock); #1;
    retire = 1'b0;
    @(negedge clock);
    read_chk("minstret write then retire", 12'hB02, 32'h11);
    @(posedge clock); #1;
    drive(1'b1, 2'b01, 1'b0, 12'hB82, 32'hA);
    @(posedge clock); #1;
    drive(1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    @(negedge clock);
    read_chk("minstreth written", 12'hB82, 32'hA);
    read_chk("minstret low kept", 12'hB02, 32'h11);

    // mcycle carry from low half into high half.
    @(posedge clock); #1;
    drive(1'b1, 2'b01, 1'b0, 12'hB00, 32'hFFFFFFFF);
    @(posedge clock); #1;
    drive(1'b1, 2'b01, 1'b0, 12'hB80, 32'h0);
    @(posedge clock); #1;
    drive(1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    read_chk("mcycleh after carry", 12'hB80, 32'h1);
    read_chk("mcycle after carry", 12'hB00, 32'h1);
    read_chk("cycleh alias", 12'hC80, 32'h1);

    // 64-bit wrap to zero.
    @(posedge clock); #1;
    drive(1'b1, 2'b01, 1'b0, 12'hB80, 32'hFFFFFFFF);
    @(posedge clock); #1;
    drive(1'b1, 2'b01, 1'b0, 12'hB00, 32'hFFFFFFFF);
    @(posedge clock); #1;
    drive(1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    @(posedge clock);
    @(negedge clock);
    read_chk("mcycle wrap low", 12'hB00, 32'h0);
    read_chk("mcycle wrap high", 12'hB80, 32'h0);

    // Async reset in the middle of a write cycle.
    @(posedge clock); #1;
    drive(1'b1, 2'b01, 1'b0, 12'h300, 32'h8);
    @(posedge clock); #1;
    drive(1'b1, 2'b01, 1'b0, 12'h340, 32'h77);
    check("mie set before reset", mie_out, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid-cycle reset mtvec_out", mtvec_out, 32'h0);
    check("mid-cycle reset mepc_out", mepc_out, 32'h0);
    check("mid-cycle reset mie_out", mie_out, 1'b0);
    check("mid-cycle reset rdata", bus.rdata, 32'h0);
    check("mid-cycle reset illegal", bus.illegal, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    read_chk("mcycle restarts", 12'hB00, 32'h1);
    read_chk("mcycleh cleared", 12'hB80, 32'h0);
    read_chk("mscratch cleared", 12'h340, 32'h0);
    read_chk("minstret cleared", 12'hB02, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
